// File: rtl/divisor_pkg.sv
// rtl/divisor_pkg.sv - shared types and constants for the sequential divider
//
// Purpose: FSM state encoding, default operand width and the counter-width
// helper used by divisor_seq_ula and div_passo.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int DIV_WIDTH = 8;

  // Bits needed to hold values 0..value-1 (value >= 2).
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_passo.sv
// rtl/div_passo.sv - one combinational restoring-division step
//
// Purpose: shifts the partial remainder left by one with bit_in entering the
// LSB, then subtracts the divisor when it fits.
// Ports:
//   rem      in   WIDTH  partial remainder (always < divisor)
//   bit_in   in   1      next dividend bit, MSB first
//   divisor  in   WIDTH  divisor magnitude
//   rem_next out  WIDTH  partial remainder after this step
//   q_bit    out  1      quotient bit produced by this step
module div_passo
  import divisor_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit keeps the subtraction free of overflow; its MSB is the borrow.
  assign shifted  = {rem, bit_in};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divisor_seq_ula.sv
// rtl/divisor_seq_ula.sv - multi-cycle restoring divider with start/busy/done
//
// Purpose: computes quotient and remainder one bit per clock, plus
// divide-by-zero and non-zero-remainder flags for the ULA.
// Optional build macro: DIV_SIGNED_EN (two's-complement operands, quotient
// truncates toward zero, remainder takes the dividend's sign).
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      request a division (accepted in IDLE or DONE)
//   dividendo  in   WIDTH  dividend, captured on accepted start
//   divisor    in   WIDTH  divisor, captured on accepted start
//   busy       out  1      high while calculating
//   done       out  1      one-cycle pulse when results are valid
//   quociente  out  WIDTH  quotient, held until the next result
//   resto      out  WIDTH  remainder, held until the next result
//   err_div0   out  1      divisor was zero
//   resto_nz   out  1      remainder is non-zero
module divisor_seq_ula
  import divisor_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             err_div0,
  output logic             resto_nz
);

  localparam int CW = clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;   // remaining dividend bits, quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             accept;

  assign accept = start && (state_q != CALC);
  assign q_raw  = {dvd_q[WIDTH-2:0], q_bit};

  div_passo #(.WIDTH(WIDTH)) u_passo (
    .rem      (rem_q),
    .bit_in   (dvd_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_r_q;

  // Negating the most-negative value yields itself, which read as unsigned
  // is the correct magnitude.
  assign a_mag = dividendo[WIDTH-1] ? -dividendo : dividendo;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_fix = neg_q_q ? -q_raw : q_raw;
  assign r_fix = neg_r_q ? -rem_nx : rem_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept) begin
      neg_q_q <= dividendo[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_q <= dividendo[WIDTH-1];
    end
  end
`else
  assign a_mag = dividendo;
  assign b_mag = divisor;
  assign q_fix = q_raw;
  assign r_fix = rem_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = (divisor == '0) ? DONE : CALC;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quociente <= '0;
      resto     <= '0;
      err_div0  <= 1'b0;
      resto_nz  <= 1'b0;
    end else if (accept) begin
      dvd_q <= a_mag;
      dvs_q <= b_mag;
      rem_q <= '0;
      cnt_q <= CW'(WIDTH - 1);
      // Division by zero skips CALC, so its results are loaded right here.
      if (divisor == '0) begin
        quociente <= '0;
        resto     <= '0;
        err_div0  <= 1'b1;
        resto_nz  <= 1'b0;
      end
    end else if (state_q == CALC) begin
      rem_q <= rem_nx;
      dvd_q <= q_raw;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) begin
        quociente <= q_fix;
        resto     <= r_fix;
        err_div0  <= 1'b0;
        resto_nz  <= (rem_nx != '0);
      end
    end
  end

endmodule

// File: tb/tb_divisor_seq_ula.sv
// tb/tb_divisor_seq_ula.sv - scoreboard testbench for divisor_seq_ula
module tb_divisor_seq_ula;

  localparam int W = 8;

  logic         clk, rst_n, start;
  logic [W-1:0] dividendo, divisor;
  logic         busy, done;
  logic [W-1:0] quociente, resto;
  logic         err_div0, resto_nz;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    logic         nz;
  } exp_t;

  exp_t sb[$];

  divisor_seq_ula #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quociente (quociente),
    .resto     (resto),
    .err_div0  (err_div0),
    .resto_nz  (resto_nz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("busy_done_exclusive", int'(busy), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("quociente", int'(quociente), int'(e.q));
          chk("resto", int'(resto), int'(e.r));
          chk("err_div0", int'(err_div0), int'(e.err));
          chk("resto_nz", int'(resto_nz), int'(e.nz));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic eerr, input logic enz);
    exp_t e;
    @(posedge clk); #1;
    dividendo = a;
    divisor   = b;
    start     = 1'b1;
    e.q = eq; e.r = er; e.err = eerr; e.nz = enz;
    sb.push_back(e);
    @(posedge clk); #1;
    start     = 1'b0;
    dividendo = 8'hA5;
    divisor   = 8'h00;
  endtask

  // Entered in the first cycle after the accepting edge; returns in the done cycle.
  // pulse_at != 0 raises a stray start with other operands in that cycle.
  task automatic wait_done(input int lat, input string name, input int pulse_at);
    int cyc;
    int busy_cnt;
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      if (cyc == pulse_at) begin
        start = 1'b1; dividendo = 8'd50; divisor = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({name, "_latency"}, cyc, lat);
    chk({name, "_busy_cycles"}, busy_cnt, lat - 1);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b1; start = 1'b0; dividendo = '0; divisor = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quociente), 0);
    chk("rst_r", int'(resto), 0);
    chk("rst_err", int'(err_div0), 0);
    chk("rst_nz", int'(resto_nz), 0);
    #19 rst_n = 1'b1;

`ifdef DIV_SIGNED_EN
    launch(8'd200, 8'd7, 8'hF8, 8'h00, 1'b0, 1'b0);
`else
    launch(8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 1'b1);
`endif
    wait_done(9, "d200_7", 0);

    // Back-to-back: second start is presented during the first done cycle.
    launch(8'd255, 8'd1, 8'hFF, 8'h00, 1'b0, 1'b0);
    wait_done(9, "b2b_first", 0);
    dividendo = 8'd7; divisor = 8'd9; start = 1'b1;
    e.q = 8'h00; e.r = 8'h07; e.err = 1'b0; e.nz = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; dividendo = 8'hA5; divisor = 8'h00;
    wait_done(9, "b2b_second", 0);

    launch(8'd13, 8'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_done(1, "div0", 0);

    launch(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 1'b1);
    wait_done(9, "ignored_start", 3);

    // Abort mid-calculation with reset; no result is expected.
    @(posedge clk); #1;
    dividendo = 8'd200; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("held_q_during_calc", int'(quociente), 33);
    chk("held_r_during_calc", int'(resto), 1);
    chk("busy_during_calc", int'(busy), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(quociente), 0);
    chk("abort_r", int'(resto), 0);
    chk("abort_err", int'(err_div0), 0);
    chk("abort_nz", int'(resto_nz), 0);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_no_done", int'(done), 0);

    launch(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);
    wait_done(9, "d9_3", 0);

`ifdef DIV_SIGNED_EN
    launch(8'h80, 8'h81, 8'h01, 8'hFF, 1'b0, 1'b1);
    wait_done(9, "s_m128_m127", 0);
    launch(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b1);
    wait_done(9, "s_m7_2", 0);
    launch(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0);
    wait_done(9, "s_min_m1", 0);
    launch(8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b1);
    wait_done(9, "s_7_m2", 0);
`else
    launch(8'h80, 8'h81, 8'h00, 8'h80, 1'b0, 1'b1);
    wait_done(9, "u128_129", 0);
    launch(8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
    wait_done(9, "u255_255", 0);
    launch(8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_done(9, "u0_5", 0);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
